// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the multi-cycle MIPS-subset CPU.
// Walks each instruction through fetch/decode/execute/memory/writeback, stalls
// on the shared memory port's ready handshake, counts retired instructions and
// traps into HALT on the halt opcode or on any unsupported encoding.
module multicycle_controller #(
  parameter int ALU_OP_W   = 3,
  parameter int CNT_W      = 32,
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instruction,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_reg,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_src,
  output logic                halted,
  output logic                illegal,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    MEM_ADDR = 4'd3,
    EXEC_I   = 4'd4,
    BRANCH   = 4'd5,
    JUMP     = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WR   = 4'd8,
    WB_R     = 4'd9,
    WB_MEM   = 4'd10,
    WB_I     = 4'd11,
    HALT     = 4'd12
  } state_t;

  // Every datapath control line that is a pure function of the state.
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                mem_read;
    logic                mem_write;
    logic                i_or_d;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_reg;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic [1:0]          pc_src;
    logic                halted;
  } ctrl_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(6);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  state_t     state_q;
  state_t     next_state;
  ctrl_t      ctrl_q;
  logic       set_illegal;
  logic       retire;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       funct_ok;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  // Register and shift fields belong to the datapath, not to control.
  wire unused_fields = ^instruction[25:6];

  // R-type funct codes this machine knows how to execute.
  assign funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                    (funct == 6'h25) || (funct == 6'h2a);

  function automatic logic [ALU_OP_W-1:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h2a:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Control word to present while sitting in state s. The funct and bne bits
  // are taken from the IR on the edge that enters s; the IR is stable then.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] f,
                                     input logic is_bne);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      DECODE: c.alu_src_b = 2'd3;
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = funct_to_alu(f);
      end
      MEM_ADDR, EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'd1;
        c.branch_ne     = is_bne;
      end
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'd2;
      end
      MEM_RD: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      MEM_WR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      WB_MEM: begin
        c.reg_write = 1'b1;
        c.mem_reg   = 1'b1;
      end
      WB_I:    c.reg_write = 1'b1;
      HALT:    c.halted    = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state, illegal-trap and retire decisions for the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    next_state  = state_q;
    set_illegal = 1'b0;
    retire      = 1'b0;
    case (state_q)
      FETCH: if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct_ok) begin
              next_state = EXEC_R;
            end else begin
              next_state  = HALT;
              set_illegal = 1'b1;
            end
          end
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_ADDI:      next_state = EXEC_I;
          OP_BEQ:       next_state = BRANCH;
          OP_BNE: begin
            if (ENABLE_BNE) begin
              next_state = BRANCH;
            end else begin
              next_state  = HALT;
              set_illegal = 1'b1;
            end
          end
          OP_J:    next_state = JUMP;
          OP_HALT: next_state = HALT;
          default: begin
            next_state  = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      EXEC_R:   next_state = WB_R;
      MEM_ADDR: next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      EXEC_I:   next_state = WB_I;
      MEM_RD:   if (mem_ready) next_state = WB_MEM;
      MEM_WR: begin
        if (mem_ready) begin
          next_state = FETCH;
          retire     = 1'b1;
        end
      end
      WB_R, WB_MEM, WB_I, BRANCH, JUMP: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  // State, registered control word, sticky illegal flag and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_for(FETCH, 6'h00, 1'b0);
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= next_state;
      ctrl_q  <= ctrl_for(next_state, funct, opcode == OP_BNE);
      if (set_illegal) illegal <= 1'b1;
      if (retire)      retired <= retired + CNT_W'(1);
    end
  end

  // The IR latch and PC increment in FETCH complete with the memory read.
  assign ir_write      = (state_q == FETCH) && mem_ready;
  assign pc_write      = ctrl_q.pc_write || ir_write;
  assign alu_op        = ctrl_q.alu_op;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign i_or_d        = ctrl_q.i_or_d;
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_reg       = ctrl_q.mem_reg;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign branch_ne     = ctrl_q.branch_ne;
  assign pc_src        = ctrl_q.pc_src;
  assign halted        = ctrl_q.halted;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed plus randomized checks of the multi-cycle
// controller against a phase-list reference model of each instruction class.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        mem_ready = 1'b0;

  logic [2:0]  alu_op;
  logic        alu_src_a, mem_read, mem_write, i_or_d, ir_write, reg_write;
  logic        reg_dst, mem_reg, pc_write, pc_write_cond, branch_ne, halted, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  state;
  logic [31:0] retired;

  logic [2:0]  nb_alu_op;
  logic        nb_alu_src_a, nb_mem_read, nb_mem_write, nb_i_or_d, nb_ir_write, nb_reg_write;
  logic        nb_reg_dst, nb_mem_reg, nb_pc_write, nb_pc_write_cond, nb_branch_ne, nb_halted, nb_illegal;
  logic [1:0]  nb_alu_src_b, nb_pc_src;
  logic [3:0]  nb_state;
  logic [31:0] nb_retired;

  logic [2:0]  w4_alu_op;
  logic        w4_alu_src_a, w4_mem_read, w4_mem_write, w4_i_or_d, w4_ir_write, w4_reg_write;
  logic        w4_reg_dst, w4_mem_reg, w4_pc_write, w4_pc_write_cond, w4_branch_ne, w4_halted, w4_illegal;
  logic [1:0]  w4_alu_src_b, w4_pc_src;
  logic [3:0]  w4_state;
  logic [3:0]  w4_retired;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_reg(mem_reg), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .pc_src(pc_src),
    .halted(halted), .illegal(illegal), .state(state), .retired(retired)
  );

  multicycle_controller #(.ENABLE_BNE(1'b0)) dut_nobne (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
    .alu_op(nb_alu_op), .alu_src_a(nb_alu_src_a), .alu_src_b(nb_alu_src_b),
    .mem_read(nb_mem_read), .mem_write(nb_mem_write), .i_or_d(nb_i_or_d), .ir_write(nb_ir_write),
    .reg_write(nb_reg_write), .reg_dst(nb_reg_dst), .mem_reg(nb_mem_reg), .pc_write(nb_pc_write),
    .pc_write_cond(nb_pc_write_cond), .branch_ne(nb_branch_ne), .pc_src(nb_pc_src),
    .halted(nb_halted), .illegal(nb_illegal), .state(nb_state), .retired(nb_retired)
  );

  multicycle_controller #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
    .alu_op(w4_alu_op), .alu_src_a(w4_alu_src_a), .alu_src_b(w4_alu_src_b),
    .mem_read(w4_mem_read), .mem_write(w4_mem_write), .i_or_d(w4_i_or_d), .ir_write(w4_ir_write),
    .reg_write(w4_reg_write), .reg_dst(w4_reg_dst), .mem_reg(w4_mem_reg), .pc_write(w4_pc_write),
    .pc_write_cond(w4_pc_write_cond), .branch_ne(w4_branch_ne), .pc_src(w4_pc_src),
    .halted(w4_halted), .illegal(w4_illegal), .state(w4_state), .retired(w4_retired)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference-model bookkeeping.
  logic [31:0] model_retired = 32'h0;
  int          phases[$];
  int          data_read_cycles;
  int          instr_cycles;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       mrd, mwr, iord, irw, rw, rdst, mreg, pcw, pcwc, bne;
    logic [1:0] pcsrc;
    logic       halted;
  } ctrl_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic ctrl_t dut_ctrl();
    return {alu_op, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d, ir_write,
            reg_write, reg_dst, mem_reg, pc_write, pc_write_cond, branch_ne, pc_src, halted};
  endfunction

  // Control values the datapath should see in a given phase of the instruction.
  function automatic ctrl_t expect_for(input int p, input logic [31:0] ins, input logic rdy);
    ctrl_t e;
    e = '0;
    case (p)
      0: begin e.mrd = 1'b1; e.src_b = 2'd1; e.irw = rdy; e.pcw = rdy; end
      1: e.src_b = 2'd3;
      2: begin
        e.src_a = 1'b1;
        case (ins[5:0])
          6'h22:   e.alu_op = 3'd6;
          6'h24:   e.alu_op = 3'd2;
          6'h25:   e.alu_op = 3'd1;
          6'h2a:   e.alu_op = 3'd4;
          default: e.alu_op = 3'd0;
        endcase
      end
      3, 4: begin e.src_a = 1'b1; e.src_b = 2'd2; end
      5: begin
        e.src_a = 1'b1; e.alu_op = 3'd6; e.pcwc = 1'b1; e.pcsrc = 2'd1;
        e.bne = (ins[31:26] == 6'h05);
      end
      6: begin e.pcw = 1'b1; e.pcsrc = 2'd2; end
      7: begin e.iord = 1'b1; e.mrd = 1'b1; end
      8: begin e.iord = 1'b1; e.mwr = 1'b1; end
      9: begin e.rw = 1'b1; e.rdst = 1'b1; end
      10: begin e.rw = 1'b1; e.mreg = 1'b1; end
      11: e.rw = 1'b1;
      12: e.halted = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // The sequence of states a legal instruction walks through before retiring.
  task automatic build_phases(input logic [31:0] ins);
    phases = '{0, 1};
    case (ins[31:26])
      6'h00:        begin phases.push_back(2); phases.push_back(9); end
      6'h23:        begin phases.push_back(3); phases.push_back(7); phases.push_back(10); end
      6'h2b:        begin phases.push_back(3); phases.push_back(8); end
      6'h08:        begin phases.push_back(4); phases.push_back(11); end
      6'h04, 6'h05: phases.push_back(5);
      default:      phases.push_back(6);
    endcase
  endtask

  // Run one legal instruction. mode 0: ready always 1; mode 1: random ready;
  // mode 2: ready low for the first two cycles of each data-memory wait.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int mode);
    int idx    = 0;
    int stalls = 2;
    int p;
    instruction      = ins;
    data_read_cycles = 0;
    instr_cycles     = 0;
    build_phases(ins);
    while (idx < phases.size() && instr_cycles < 200) begin
      @(negedge clk);
      p = phases[idx];
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ($urandom_range(0, 2) != 0);
        default: begin
          mem_ready = 1'b1;
          if ((p == 7 || p == 8) && stalls > 0) begin
            mem_ready = 1'b0;
            stalls--;
          end
        end
      endcase
      #1;
      if (instr_cycles == 0) check({tag, ".retired_before"}, 64'(retired), 64'(model_retired));
      check({tag, ".state"}, 64'(state), 64'(p));
      check({tag, ".ctrl"}, 64'(dut_ctrl()), 64'(expect_for(p, ins, mem_ready)));
      if (mem_read && i_or_d) data_read_cycles++;
      instr_cycles++;
      if (!(p == 0 || p == 7 || p == 8) || mem_ready) idx++;
    end
    model_retired++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_retired = 32'h0;
    check("reset.state", 64'(state), 64'd0);
    check("reset.retired", 64'(retired), 64'd0);
    check("reset.illegal", 64'(illegal), 64'd0);
    check("reset.ctrl", 64'(dut_ctrl()), 64'(expect_for(0, 32'h0, 1'b0)));
  endtask

  function automatic logic [31:0] random_legal();
    logic [5:0]  functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [5:0]  iops   [6] = '{6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h02};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 2) == 0)
      return {6'h00, r[25:6], functs[$urandom_range(0, 4)]};
    return {iops[$urandom_range(0, 5)], r[25:0]};
  endfunction

  function automatic bit is_legal_op(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b, 6'h3f};
  endfunction

  logic [31:0] ins_tmp;
  logic [31:0] frozen;

  initial begin
    do_reset();

    // Directed add: states 0,1,2,9 then back to FETCH.
    run_instr("add", 32'h00221820, 0);
    check("add.cycles", 64'(instr_cycles), 64'd4);

    // lw with two wait cycles in MEM_RD: seven cycles, three data reads.
    run_instr("lw_stall", 32'h8c410004, 2);
    check("lw_stall.cycles", 64'(instr_cycles), 64'd7);
    check("lw_stall.data_reads", 64'(data_read_cycles), 64'd3);

    run_instr("sw", 32'hac410008, 0);
    check("sw.cycles", 64'(instr_cycles), 64'd4);
    run_instr("beq", 32'h10220003, 0);
    check("beq.cycles", 64'(instr_cycles), 64'd3);
    run_instr("bne", 32'h14220003, 0);
    run_instr("j", 32'h08000010, 0);

    // Randomized instruction mix with random memory stalls.
    for (int i = 0; i < 60; i++) begin
      ins_tmp = random_legal();
      run_instr("rand", ins_tmp, 1);
    end

    // Halt opcode: two cycles to HALT, then frozen for 100 cycles.
    instruction = 32'hfc000000;
    @(negedge clk); mem_ready = 1'b1; #1;
    check("halt.retired_before", 64'(retired), 64'(model_retired));
    check("halt.fetch", 64'(state), 64'd0);
    @(negedge clk); #1;
    check("halt.decode", 64'(state), 64'd1);
    @(negedge clk); #1;
    check("halt.state", 64'(state), 64'd12);
    check("halt.illegal", 64'(illegal), 64'd0);
    frozen = model_retired;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1;
      check("halt.hold_state", 64'(state), 64'd12);
      check("halt.hold_ctrl", 64'(dut_ctrl()), 64'(expect_for(12, instruction, mem_ready)));
      check("halt.retired_frozen", 64'(retired), 64'(frozen));
    end

    // Unsupported opcode traps with illegal set; reset clears it.
    do_reset();
    do ins_tmp = $urandom; while (is_legal_op(ins_tmp[31:26]));
    instruction = ins_tmp;
    mem_ready   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("bad_op.state", 64'(state), 64'd12);
    check("bad_op.halted", 64'(halted), 64'd1);
    check("bad_op.illegal", 64'(illegal), 64'd1);

    // Unsupported R-type funct (0x21) is illegal too.
    do_reset();
    instruction = 32'h00221821;
    mem_ready   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("bad_funct.halted", 64'(halted), 64'd1);
    check("bad_funct.illegal", 64'(illegal), 64'd1);

    // bne traps when disabled, branches when enabled.
    do_reset();
    instruction = 32'h14220003;
    mem_ready   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("nobne.state", 64'(nb_state), 64'd12);
    check("nobne.halted", 64'(nb_halted), 64'd1);
    check("nobne.illegal", 64'(nb_illegal), 64'd1);
    check("bne_en.state", 64'(state), 64'd5);
    check("bne_en.branch_ne", 64'(branch_ne), 64'd1);

    // Reset during a stalled store abandons it and clears the counter.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ins_tmp = random_legal();
      run_instr("pre_rst", ins_tmp, 1);
    end
    instruction = 32'hac410008;
    mem_ready   = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("sw_wait.state", 64'(state), 64'd8);
      check("sw_wait.mem_write", 64'(mem_write), 64'd1);
    end
    check("sw_wait.retired", 64'(retired), 64'(model_retired));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid.state", 64'(state), 64'd0);
    check("rst_mid.mem_write", 64'(mem_write), 64'd0);
    check("rst_mid.retired", 64'(retired), 64'd0);
    check("rst_mid.ctrl", 64'(dut_ctrl()), 64'(expect_for(0, instruction, mem_ready)));

    // 17 jumps wrap a 4-bit counter to 1.
    do_reset();
    instruction = 32'h08000000;
    mem_ready   = 1'b1;
    repeat (51) @(negedge clk);
    #1;
    check("wrap.w4_retired", 64'(w4_retired), 64'd1);
    check("wrap.retired32", 64'(retired), 64'd17);
    check("wrap.state", 64'(state), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
